// File: rtl/hilo_unit_if.sv
// hilo_unit pipeline-side and multiplier-side signal bundle.
// slave = hilo_unit, master = pipeline + multiplier side.
interface hilo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_c;

  modport slave (
    input  op_valid, op, op_a, op_b,
    input  flush, mul_done, mul_c,
    output op_ready, busy, hi, lo,
    output mul_valid, mul_a, mul_b
  );

  modport master (
    output op_valid, op, op_a, op_b,
    output flush, mul_done, mul_c,
    input  op_ready, busy, hi, lo,
    input  mul_valid, mul_a, mul_b
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file and multiply/accumulate sequencer.
// Feeds an unsigned multiplier with magnitudes, fixes sign on capture.
module hilo_unit (
  input  logic  clk,
  input  logic  resetn,
  hilo_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic        sa_q;
  logic        sb_q;
  logic        kill_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mula_q;
  logic [31:0] mulb_q;

  logic        idle;
  logic        accept;
  logic        is_mul;
  logic        is_sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod;
  logic [63:0] acc;
  logic [63:0] res;
  logic        wr;

  assign idle   = (state == IDLE);
  assign accept = bus.op_valid && idle
                  && !bus.flush;
  assign is_mul = (bus.op != OP_NOP)
                  && (bus.op < OP_MTHI);
  assign is_sgn = (bus.op == OP_MULT)
                  || (bus.op == OP_MADD)
                  || (bus.op == OP_MSUB);

  // 0x80000000 maps to itself, which is its
  // correct magnitude read as unsigned.
  assign abs_a = bus.op_a[31] ? 32'd0 - bus.op_a
                              : bus.op_a;
  assign abs_b = bus.op_b[31] ? 32'd0 - bus.op_b
                              : bus.op_b;

  assign bus.op_ready  = idle;
  assign bus.busy      = !idle;
  assign bus.mul_valid = (state == LAUNCH);
  assign bus.mul_a     = mula_q;
  assign bus.mul_b     = mulb_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: always drain through CAPTURE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sign fix-up and accumulate on the product.
  always_comb begin
    prod = bus.mul_c;
    if (sa_q ^ sb_q) begin
      prod = 64'd0 - bus.mul_c;
    end
    acc = {hi_q, lo_q};
    res = prod;
    unique case (1'b1)
      (op_q == OP_MADD),
      (op_q == OP_MADDU): res = acc + prod;
      (op_q == OP_MSUB):  res = acc - prod;
      default:            res = prod;
    endcase
    // A flush landing on CAPTURE still discards.
    wr = (state == CAPTURE)
         && !kill_q && !bus.flush;
  end

  // Latch op, sign flags and operands; track kill.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q   <= OP_NOP;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      kill_q <= 1'b0;
      mula_q <= 32'd0;
      mulb_q <= 32'd0;
    end else if (accept && is_mul) begin
      op_q   <= bus.op;
      sa_q   <= is_sgn && bus.op_a[31];
      sb_q   <= is_sgn && bus.op_b[31];
      kill_q <= 1'b0;
      mula_q <= is_sgn ? abs_a : bus.op_a;
      mulb_q <= is_sgn ? abs_b : bus.op_b;
    end else if (!idle && bus.flush) begin
      kill_q <= 1'b1;
    end
  end

  // Architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (wr) begin
      hi_q <= res[63:32];
      lo_q <= res[31:0];
    end else if (accept) begin
      if (bus.op == OP_MTHI) begin
        hi_q <= bus.op_a;
      end
      if (bus.op == OP_MTLO) begin
        lo_q <= bus.op_a;
      end
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: multiplier model, per-cycle
// compare against a plain-arithmetic HI/LO model.
module tb_hilo_unit;
  logic clk;
  logic resetn;
  hilo_unit_if bus ();

  hilo_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Multiplier: result appears only once finished.
  int          lat;
  int          cnt;
  logic [63:0] prod_q;
  logic [63:0] mc_q;

  always @(posedge clk) begin
    if (!resetn) begin
      cnt    <= 0;
      prod_q <= 64'd0;
      mc_q   <= 64'd0;
    end else if (bus.mul_valid) begin
      cnt    <= lat;
      prod_q <= {32'd0, bus.mul_a}
                * {32'd0, bus.mul_b};
      mc_q   <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mc_q <= prod_q;
    end
  end

  assign bus.mul_done = (cnt <= 1);
  assign bus.mul_c    = mc_q;

  // Model state.
  logic [63:0] m_hilo;
  logic        m_busy;
  logic        m_mulv;
  logic [31:0] m_mula;
  logic [31:0] m_mulb;
  logic        chk_en;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(
      input logic [2:0]  o,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [63:0] acc);
    longint sa;
    longint sb;
    logic [63:0] sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    sp = 64'(sa * sb);
    up = {32'd0, a} * {32'd0, b};
    case (o)
      3'd1:    return sp;
      3'd2:    return up;
      3'd3:    return acc + sp;
      3'd4:    return acc + up;
      3'd5:    return acc - sp;
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] mag(
      input logic sgn, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (sgn && v[31]) r = 32'd0 - v;
    return r;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", {32'd0, bus.hi},
          {32'd0, m_hilo[63:32]});
      chk("lo", {32'd0, bus.lo},
          {32'd0, m_hilo[31:0]});
      chk("busy", {63'd0, bus.busy},
          {63'd0, m_busy});
      chk("op_ready", {63'd0, bus.op_ready},
          {63'd0, !m_busy});
      chk("mul_valid", {63'd0, bus.mul_valid},
          {63'd0, m_mulv});
      if (m_busy) begin
        chk("mul_a", {32'd0, bus.mul_a},
            {32'd0, m_mula});
        chk("mul_b", {32'd0, bus.mul_b},
            {32'd0, m_mulb});
      end
    end
  end

  // Single-cycle op (MTHI/MTLO/NOP), optional flush.
  task automatic mov(input logic [2:0] o,
                     input logic [31:0] a,
                     input logic fl);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.op_a     = a;
    bus.op_b     = 32'd0;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    if (!fl && o == 3'd6) m_hilo[63:32] = a;
    if (!fl && o == 3'd7) m_hilo[31:0]  = a;
  endtask

  // Multiply op. fl_at/rs_at: busy cycle number
  // (2 = first WAIT) carrying flush / reset.
  task automatic mul(input logic [2:0]  o,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int          l,
                     input int          fl_at,
                     input int          rs_at,
                     input logic        hold,
                     input logic [31:0] hv);
    logic sgn;
    logic killed;
    sgn    = (o == 3'd1) || (o == 3'd3)
             || (o == 3'd5);
    killed = 1'b0;
    lat    = l;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    m_busy = 1'b1;
    m_mulv = 1'b1;
    m_mula = mag(sgn, a);
    m_mulb = mag(sgn, b);
    if (hold) begin
      bus.op   = 3'd7;
      bus.op_a = hv;
      bus.op_b = 32'h5555_5555;
    end else begin
      bus.op_valid = 1'b0;
      bus.op_a     = 32'h0BAD_0BAD;
      bus.op_b     = 32'h0BAD_0BAD;
    end
    @(posedge clk);
    #1;
    m_mulv = 1'b0;
    for (int c = 2; c <= l + 2; c++) begin
      bus.flush = (c == fl_at);
      if (c == fl_at) killed = 1'b1;
      if (c == rs_at) resetn = 1'b0;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      if (c == rs_at) begin
        resetn = 1'b1;
        m_hilo = 64'd0;
        m_busy = 1'b0;
        return;
      end
    end
    m_busy = 1'b0;
    if (!killed) m_hilo = model(o, a, b, m_hilo);
    if (hold) begin
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      m_hilo[31:0] = hv;
    end
  endtask

  function automatic logic [63:0] hilo();
    return {bus.hi, bus.lo};
  endfunction

  initial begin
    chk_en       = 1'b0;
    resetn       = 1'b0;
    lat          = 1;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    bus.flush    = 1'b0;
    m_hilo       = 64'd0;
    m_busy       = 1'b0;
    m_mulv       = 1'b0;
    m_mula       = 32'd0;
    m_mulb       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    chk("rst_hilo", hilo(), 64'd0);
    chk("rst_mul_a", {32'd0, bus.mul_a}, 64'd0);
    chk("rst_mul_b", {32'd0, bus.mul_b}, 64'd0);
    chk("rst_ready", {63'd0, bus.op_ready}, 64'd1);

    mov(3'd6, 32'hDEAD_BEEF, 1'b0);
    chk("mthi", {32'd0, bus.hi}, 64'hDEAD_BEEF);
    mov(3'd7, 32'h1234_5678, 1'b0);
    chk("mtlo", hilo(), 64'hDEADBEEF_12345678);

    mul(3'd1, 32'hFFFF_FFFF, 32'd2,
        33, 0, 0, 1'b0, 32'd0);
    chk("mult_neg", hilo(), 64'hFFFFFFFF_FFFFFFFE);

    mul(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        5, 0, 0, 1'b0, 32'd0);
    chk("multu_max", hilo(), 64'hFFFFFFFE_00000001);

    mul(3'd1, 32'h8000_0000, 32'h8000_0000,
        1, 0, 0, 1'b0, 32'd0);
    chk("mult_min", hilo(), 64'h40000000_00000000);

    mov(3'd6, 32'd0, 1'b0);
    mov(3'd7, 32'hFFFF_FFFF, 1'b0);
    mul(3'd4, 32'd1, 32'd1,
        3, 0, 0, 1'b0, 32'd0);
    chk("maddu", hilo(), 64'h00000001_00000000);
    mul(3'd5, 32'd2, 32'd3,
        4, 0, 0, 1'b0, 32'd0);
    chk("msub", hilo(), 64'h00000000_FFFFFFFA);
    mul(3'd3, 32'hFFFF_FFFD, 32'd7,
        2, 0, 0, 1'b0, 32'd0);
    chk("madd_neg", hilo(), 64'h00000000_FFFFFFE5);

    mul(3'd1, 32'd3, 32'd5,
        6, 3, 0, 1'b0, 32'd0);
    chk("flush_keep", hilo(), 64'h00000000_FFFFFFE5);
    mul(3'd1, 32'd3, 32'd5,
        6, 0, 0, 1'b0, 32'd0);
    chk("after_flush", hilo(), 64'd15);

    mov(3'd6, 32'h0000_00AA, 1'b0);
    mul(3'd1, 32'd7, 32'd9,
        8, 0, 4, 1'b0, 32'd0);
    chk("rst_mid", hilo(), 64'd0);
    chk("rst_mid_a", {32'd0, bus.mul_a}, 64'd0);

    mul(3'd1, 32'hFFFF_FFFE, 32'd4,
        4, 0, 0, 1'b1, 32'hA5A5_A5A5);
    chk("held_mtlo", hilo(), 64'hFFFFFFFF_A5A5A5A5);

    mov(3'd6, 32'h0000_1234, 1'b1);
    chk("idle_flush", hilo(), 64'hFFFFFFFF_A5A5A5A5);
    mov(3'd0, 32'h0000_5678, 1'b0);
    chk("nop", hilo(), 64'hFFFFFFFF_A5A5A5A5);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
